// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter.
//   arb_state_e : arbiter FSM states (IDLE, LOCK)
//   rr_first()  : first requester with req set, searching upward from ptr
//                 and wrapping at n-1 (supports up to RR_MAX_N requesters)
package axis_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int unsigned RR_MAX_N = 8;
    localparam int unsigned RR_IDX_W = 3;

    // Rotating priority search; returns ptr when no request is set.
    function automatic logic [RR_IDX_W-1:0] rr_first(
        input logic [RR_MAX_N-1:0] req,
        input logic [RR_IDX_W-1:0] ptr,
        input int unsigned         n
    );
        logic [RR_IDX_W-1:0] sel;
        logic                found;
        int unsigned         idx;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX_N; k++) begin
            idx = (32'(ptr) + k) % n;
            if (!found && (k < n) && req[RR_IDX_W'(idx)]) begin
                sel   = RR_IDX_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_pipe.sv
// Single-entry register slice for the arbiter output.
//   clk, reset          : clock, asynchronous active-high reset
//   di_valid, di_data   : beat to load (loaded when di_hold is low)
//   di_hold             : slice full and downstream stalled
//   do_valid, do_data   : registered output beat
//   do_ready            : downstream ready
module axis_rr_arbiter_pipe #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         di_valid,
    input  logic [W-1:0] di_data,
    output logic         di_hold,
    output logic         do_valid,
    output logic [W-1:0] do_data,
    input  logic         do_ready
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign di_hold  = valid_q & ~do_ready;
    assign do_valid = valid_q;
    assign do_data  = data_q;

    // Data only changes on a load, so it holds while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (di_valid && !di_hold) begin
            valid_q <= 1'b1;
            data_q  <= di_data;
        end else if (do_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter merging N AXI-Stream sources into one.
// A grant is held for a whole packet (until tlast) or force-released after
// MAX_BEATS beats, in which case the last beat is tagged tlast and err_long
// pulses.
//   clk, reset                  : clock, asynchronous active-high reset
//   s_axis_tvalid/tready/tlast  : per-requester handshake and end of packet
//   s_axis_tdata                : packed data, requester i at [i*DW +: DW]
//   m_axis_tvalid/tready/tlast  : merged output stream
//   m_axis_tdata, m_axis_tid    : output beat and its source index
//   err_long                    : one-cycle pulse on a forced release
module axis_rr_arbiter
    import axis_rr_arbiter_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned DW        = 24,
    parameter int unsigned MAX_BEATS = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         s_axis_tvalid,
    output logic [N-1:0]         s_axis_tready,
    input  logic [N*DW-1:0]      s_axis_tdata,
    input  logic [N-1:0]         s_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [DW-1:0]        m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic [$clog2(N)-1:0] m_axis_tid,
    output logic                 err_long
);

    localparam int unsigned TID_W = $clog2(N);
    localparam int unsigned CNT_W = $clog2(MAX_BEATS) + 1;
    localparam int unsigned PW    = TID_W + 1 + DW;

    arb_state_e         state_q, state_d;
    logic [TID_W-1:0]   gnt_q, gnt_d;
    logic [TID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               di_hold;
    logic               out_ready;
    logic               cur_valid;
    logic               cur_last;
    logic [DW-1:0]      cur_data;
    logic [TID_W-1:0]   gnt_nxt;
    logic               beat_acc;
    logic               force_rel;
    logic               beat_last;
    logic [PW-1:0]      pipe_di;
    logic [PW-1:0]      pipe_do;

    // Selected requester's lane and the next round-robin winner.
    assign out_ready = ~di_hold;
    assign cur_valid = s_axis_tvalid[gnt_q];
    assign cur_last  = s_axis_tlast[gnt_q];
    assign cur_data  = DW'(s_axis_tdata >> (32'(gnt_q) * DW));
    assign gnt_nxt   = TID_W'(rr_first(RR_MAX_N'(s_axis_tvalid), RR_IDX_W'(rr_ptr_q), N));

    // Force a release on the MAX_BEATS-th beat of an unterminated packet.
    assign beat_acc  = (state_q == LOCK) && cur_valid && out_ready;
    assign force_rel = !cur_last && (cnt_q == CNT_W'(MAX_BEATS - 1));
    assign beat_last = cur_last | force_rel;

    // Next-state and ready generation.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        err_d         = 1'b0;
        s_axis_tready = '0;
        case (state_q)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    gnt_d   = gnt_nxt;
                    cnt_d   = '0;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                s_axis_tready[gnt_q] = out_ready;
                if (beat_acc) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (beat_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = (gnt_q == TID_W'(N - 1)) ? '0 : gnt_q + TID_W'(1);
                        err_d    = force_rel;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_long = err_q;

    // Output register slice carrying {tid, tlast, tdata}.
    assign pipe_di = {gnt_q, beat_last, cur_data};

    axis_rr_arbiter_pipe #(
        .W (PW)
    ) u_pipe (
        .clk      (clk),
        .reset    (reset),
        .di_valid (beat_acc),
        .di_data  (pipe_di),
        .di_hold  (di_hold),
        .do_valid (m_axis_tvalid),
        .do_data  (pipe_do),
        .do_ready (m_axis_tready)
    );

    assign {m_axis_tid, m_axis_tlast, m_axis_tdata} = pipe_do;

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameter N, default 4: number of AXI-Stream requesters; legal range 2..8.
REQ-002 Parameter DW, default 24: tdata width per requester and on the output.
REQ-003 Parameter MAX_BEATS, default 256: longest packet, in beats, before a forced release.
REQ-004 Port clk, input, 1: single clock for all logic.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port s_axis_tvalid, input, N: per-requester valid.
REQ-007 Port s_axis_tready, output, N: per-requester ready.
REQ-008 Port s_axis_tdata, input, N*DW: packed data; requester i occupies bits [i*DW +: DW].
REQ-009 Port s_axis_tlast, input, N: per-requester end of packet.
REQ-010 Port m_axis_tvalid, output, 1: output valid, towards the FIFO write side.
REQ-011 Port m_axis_tready, input, 1: output ready, driven by the FIFO.
REQ-012 Port m_axis_tdata, output, DW: output data.
REQ-013 Port m_axis_tlast, output, 1: output end of packet.
REQ-014 Port m_axis_tid, output, $clog2(N): index of the source requester for the current beat.
REQ-015 Port err_long, output, 1: one-cycle pulse when a packet is force-released.

Function
REQ-016 The arbiter state machine SHALL have two states, IDLE and LOCK.
- IDLE: no grant is held.
- LOCK: grant is held by the requester in register gnt.
REQ-017 In IDLE with any s_axis_tvalid high, the arbiter SHALL load gnt with the first requester whose valid is high, searching upward from rr_ptr and wrapping from N-1 to 0, and SHALL enter LOCK on the next cycle.
REQ-018 In IDLE, all s_axis_tready bits SHALL be 0. The first beat is therefore accepted no earlier than one cycle after the request is seen.
REQ-019 In LOCK, s_axis_tready[gnt] SHALL equal out_ready, where out_ready = ~m_axis_tvalid | m_axis_tready. All other ready bits SHALL be 0.
REQ-020 Output stage: a single register slice.
- On an accepted beat, tdata, tlast and tid (= gnt) SHALL be loaded and m_axis_tvalid set to 1.
- m_axis_tvalid SHALL clear on an m-side handshake when no new beat is loaded in the same cycle.
- Sustained throughput SHALL be 1 beat per cycle.
REQ-021 Output data, tlast and tid SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-022 A beat counter SHALL reset to 0 on entry to LOCK and increment on each accepted input beat.
REQ-023 Packet end: an accepted input beat with tlast=1 SHALL return the FSM to IDLE and set rr_ptr to (gnt+1) mod N.
REQ-024 Forced release: when the counter reaches MAX_BEATS-1 and a beat without tlast is accepted, the arbiter SHALL do all of the following.
- Force m_axis_tlast=1 on that beat.
- Pulse err_long for one cycle.
- Return to IDLE and advance rr_ptr as in REQ-023.
REQ-025 A requester that drops tvalid while locked SHALL keep the grant; the arbiter waits and no timeout applies to idle cycles.
REQ-026 Simultaneous requests SHALL be served in strict rotation. With all N valid continuously, each requester gets exactly one packet per N grants.
REQ-027 The counter width SHALL be $clog2(MAX_BEATS)+1 bits, and the counter SHALL never wrap.

Reset
REQ-028 While reset is high, the block SHALL hold the following values:
- FSM in IDLE, gnt=0, rr_ptr=0, counter=0.
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tid=0.
- err_long=0, s_axis_tready all 0.
REQ-029 Reset asserted mid-packet SHALL discard the output register contents and the grant. After release, arbitration restarts at requester 0.

Structure
REQ-030 A shared package SHALL define:
- the FSM state enum {IDLE, LOCK};
- the function computing the round-robin first-set index from (req, rr_ptr).
REQ-031 The output register slice SHALL be the existing pipe sub-module, with di_hold used as the inverse of out_ready. No other sub-module is required.
REQ-032 Expected RTL size is 150-250 lines.

Verification
REQ-033 Single requester: req 2 sends a 3-beat packet (0x11, 0x22, 0x33 with last) into a FIFO that is always ready. Required response: 3 output beats in order, tid=2, tlast only on 0x33, first output one cycle after acceptance.
REQ-034 All requesters valid from reset, each sending 2-beat packets continuously. Required response: grant order 0,1,2,3,0,1,...; tid changes only after a tlast beat.
REQ-035 Backpressure: hold m_axis_tready=0 for 5 cycles mid-packet. Required response: m_axis_tdata and tid stable, s_axis_tready[gnt]=0, no beat lost or duplicated.
REQ-036 Long packet: MAX_BEATS=4, requester 1 sends 6 beats without tlast. Required response:
- beat 4 is output with tlast=1 and err_long pulses once;
- the grant passes to the next requester;
- the remaining 2 beats form a new packet on a later grant.
REQ-037 Reset mid-packet after beat 2 of 4. Required response: outputs at their reset values during reset; after release the next grant goes to the lowest-indexed valid requester.
